// File: rtl/stage_id_fetch_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry FIFO of {inst, pc, fault} with
// MIPS branch pre-decode, branch/delay-slot pairing hold, and delay-slot/EPC tracking.
module stage_id_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INST_W-1:0]          in_inst,
    input  logic [PC_W-1:0]            in_pc,
    input  logic                       in_fault,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INST_W-1:0]          out_inst,
    output logic [PC_W-1:0]            out_pc,
    output logic                       out_fault,
    output logic                       out_bd,
    output logic [PC_W-1:0]            out_epc,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [INST_W-1:0] mem_inst  [DEPTH];
    logic [PC_W-1:0]   mem_pc    [DEPTH];
    logic              mem_fault [DEPTH];

    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic              last_was_branch;
    logic [PC_W-1:0]   last_branch_pc;

    logic              push;
    logic              pop;
    logic              head_is_branch;
    logic              head_fault;
    logic              pair_hold;

    function automatic logic is_branch(input logic [5:0] op, input logic [5:0] fn);
        logic br;
        br = 1'b0;
        case (op)
            6'b000001, 6'b000010, 6'b000011,
            6'b000100, 6'b000101, 6'b000110, 6'b000111,
            6'b010100, 6'b010101, 6'b010110, 6'b010111: br = 1'b1;
            6'b000000: br = (fn == 6'b001000) || (fn == 6'b001001);
            default:   br = 1'b0;
        endcase
        return br;
    endfunction

    assign head_is_branch = is_branch(mem_inst[rd_ptr][31:26], mem_inst[rd_ptr][5:0]);
    assign head_fault     = mem_fault[rd_ptr];

    // A lone non-faulting branch waits for its delay slot, unless it is itself a slot.
    assign pair_hold = head_is_branch & ~head_fault & (count == CW'(1)) & ~last_was_branch;

    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0) & ~pair_hold;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        out_inst  = '0;
        out_pc    = '0;
        out_fault = 1'b0;
        if (out_valid) begin
            out_inst  = mem_inst[rd_ptr];
            out_pc    = mem_pc[rd_ptr];
            out_fault = head_fault;
        end
    end

    assign out_bd  = last_was_branch & out_valid;
    assign out_epc = out_bd ? last_branch_pc : out_pc;

    // Payload storage carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr]  <= in_inst;
            mem_pc[wr_ptr]    <= in_pc;
            mem_fault[wr_ptr] <= in_fault;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            last_was_branch <= 1'b0;
            last_branch_pc  <= '0;
        end else if (flush) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            last_was_branch <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr          <= rd_ptr + AW'(1);
                last_was_branch <= head_is_branch & ~head_fault & ~last_was_branch;
                last_branch_pc  <= out_pc;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
